// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider: unsigned WIDTH_A / WIDTH_B,
// one quotient bit per cycle, results held in output registers.
module divider_seq #(
  parameter int WIDTH_A = 17,
  parameter int WIDTH_B = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  output logic [WIDTH_A-1:0] quot_out,
  output logic [WIDTH_B-1:0] rem_out,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  localparam int CW = $clog2(WIDTH_A + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH_A-1:0] dvd_q, dvd_d;
  logic [WIDTH_B-1:0] dvs_q, dvs_d;
  logic [WIDTH_B:0]   prem_q, prem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH_A-1:0] quot_q, quot_d;
  logic [WIDTH_B-1:0] rem_q, rem_d;
  logic               dz_q, dz_d;

  logic [WIDTH_B:0]   shifted;
  logic [WIDTH_B:0]   diff;
  logic [WIDTH_B:0]   step_rem;
  logic [WIDTH_A-1:0] step_dvd;
  logic               qbit;

  // Dividend bits shift out of the top of dvd_q while quotient
  // bits shift in at the bottom; after WIDTH_A steps it is the quotient.
  always_comb begin
    shifted  = (prem_q << 1)
             | (WIDTH_B+1)'(dvd_q[WIDTH_A-1]);
    qbit     = (shifted >= {1'b0, dvs_q});
    diff     = shifted - {1'b0, dvs_q};
    step_rem = qbit ? diff : shifted;
    step_dvd = (dvd_q << 1) | WIDTH_A'(qbit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE, FIN: begin
        if (en) begin
          dvd_d  = a;
          dvs_d  = b;
          prem_d = '0;
          cnt_d  = CW'(WIDTH_A - 1);
          dz_d   = (b == '0);
          if (b == '0) begin
            quot_d  = '1;
            rem_d   = WIDTH_B'(a);
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        prem_d = step_rem;
        dvd_d  = step_dvd;
        if (cnt_q == '0) begin
          quot_d  = step_dvd;
          rem_d   = step_rem[WIDTH_B-1:0];
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign quot_out = quot_q;
  assign rem_out  = rem_q;
  assign div_zero = dz_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == FIN);

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: vector table, corner
// sequences and randomized back-to-back traffic vs arithmetic model.
module tb_divider_seq;

  localparam int WA = 17;
  localparam int WB = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic [WA-1:0] quot_out;
  logic [WB-1:0] rem_out;
  logic          busy;
  logic          done;
  logic          div_zero;

  divider_seq #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a        (a),
    .b        (b),
    .quot_out (quot_out),
    .rem_out  (rem_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned q;
    int unsigned r;
    int unsigned dz;
    int          lat;
    int          nb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples cycles 1..lim after the start edge; lat is the cycle of done.
  task automatic wait_done(input int lim, output int lat,
                           output int nbusy, output logic got);
    lat   = 0;
    nbusy = 0;
    got   = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      lat = c;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (c < lim) tick();
    end
  endtask

  function automatic void ref_div(input int unsigned av,
                                  input int unsigned bv,
                                  output int unsigned q,
                                  output int unsigned r,
                                  output int unsigned dz);
    if (bv == 0) begin
      q  = (1 << WA) - 1;
      r  = av % (1 << WB);
      dz = 1;
    end else begin
      q  = av / bv;
      r  = av % bv;
      dz = 0;
    end
  endfunction

  task automatic run_op(input string tag, input vec_t v);
    int   lat;
    int   nb;
    logic got;
    en = 1'b1;
    a  = WA'(v.a);
    b  = WB'(v.b);
    tick();
    en = 1'b0;
    wait_done(40, lat, nb, got);
    check({tag, ".done_seen"}, got, 1);
    check({tag, ".quot"}, quot_out, v.q);
    check({tag, ".rem"}, rem_out, v.r);
    check({tag, ".div_zero"}, div_zero, v.dz);
    check({tag, ".latency"}, lat, v.lat);
    check({tag, ".busy_cycles"}, nb, v.nb);
    tick();
    check({tag, ".done_width"}, done, 0);
    check({tag, ".quot_hold"}, quot_out, v.q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          nb;
    logic        got;
    int          dcount;
    int unsigned cur_a, cur_b, nxt_a, nxt_b;
    int unsigned eq, er, edz;
    localparam int NRAND = 40;

    vecs[0] = '{100000, 7,   14285,  5,   0, 18, 17};
    vecs[1] = '{131071, 511, 256,    255, 0, 18, 17};
    vecs[2] = '{5,      9,   0,      5,   0, 18, 17};
    vecs[3] = '{1234,   0,   131071, 210, 1, 1,  0};
    vecs[4] = '{0,      1,   0,      0,   0, 18, 17};
    vecs[5] = '{131071, 1,   131071, 0,   0, 18, 17};
    vecs[6] = '{65536,  256, 256,    0,   0, 18, 17};
    vecs[7] = '{12345,  100, 123,    45,  0, 18, 17};
    vecs[8] = '{0,      0,   131071, 0,   1, 1,  0};
    vecs[9] = '{300,    511, 0,      300, 0, 18, 17};

    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    tick();
    tick();
    check("reset.quot", quot_out, 0);
    check("reset.rem", rem_out, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.div_zero", div_zero, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i]);

    // Second request during RUN must be ignored.
    en = 1'b1;
    a  = WA'(1000);
    b  = WB'(3);
    tick();
    en = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    a  = WA'(9);
    b  = WB'(9);
    tick();
    en = 1'b0;
    a  = '0;
    b  = '0;
    wait_done(40, lat, nb, got);
    check("ignore.done_seen", got, 1);
    check("ignore.latency", lat + 5, 18);
    check("ignore.quot", quot_out, 333);
    check("ignore.rem", rem_out, 1);
    check("ignore.div_zero", div_zero, 0);
    tick();

    // Reset in the middle of RUN aborts without done.
    en = 1'b1;
    a  = WA'(1000);
    b  = WB'(3);
    tick();
    en = 1'b0;
    repeat (7) tick();
    check("abort.busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.quot", quot_out, 0);
    check("abort.rem", rem_out, 0);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.div_zero", div_zero, 0);
    dcount = 0;
    repeat (20) begin
      if (done !== 1'b0) dcount++;
      tick();
    end
    check("abort.no_done", dcount, 0);
    run_op("after_abort", '{50, 6, 8, 2, 0, 18, 17});

    // Reset wins over a simultaneous start request.
    rst = 1'b1;
    en  = 1'b1;
    a   = WA'(10);
    b   = WB'(0);
    tick();
    check("rst_prio.busy", busy, 0);
    check("rst_prio.done", done, 0);
    check("rst_prio.div_zero", div_zero, 0);
    rst = 1'b0;
    en  = 1'b0;
    tick();
    check("rst_prio.idle_done", done, 0);

    // Randomized back-to-back traffic, en held high through FIN.
    cur_a = $urandom_range(0, (1 << WA) - 1);
    cur_b = ($urandom_range(0, 7) == 0) ? 0 :
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) :
            $urandom_range(1, (1 << WB) - 1);
    en = 1'b1;
    a  = WA'(cur_a);
    b  = WB'(cur_b);
    tick();
    for (int i = 0; i < NRAND; i++) begin
      a = WA'($urandom);
      b = WB'($urandom);
      wait_done(40, lat, nb, got);
      ref_div(cur_a, cur_b, eq, er, edz);
      check($sformatf("rand%0d.done_seen", i), got, 1);
      check($sformatf("rand%0d.quot", i), quot_out, eq);
      check($sformatf("rand%0d.rem", i), rem_out, er);
      check($sformatf("rand%0d.div_zero", i), div_zero, edz);
      check($sformatf("rand%0d.latency", i), lat,
            (cur_b == 0) ? 1 : WA + 1);
      check($sformatf("rand%0d.busy_cycles", i), nb,
            (cur_b == 0) ? 0 : WA);
      if (cur_b != 0)
        check($sformatf("rand%0d.identity", i),
              ((64'(quot_out) * cur_b + rem_out) == cur_a)
              && (rem_out < cur_b), 1);
      nxt_a = $urandom_range(0, (1 << WA) - 1);
      nxt_b = ($urandom_range(0, 7) == 0) ? 0 :
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) :
              $urandom_range(1, (1 << WB) - 1);
      if (i == NRAND - 1) en = 1'b0;
      a = WA'(nxt_a);
      b = WB'(nxt_b);
      tick();
      check($sformatf("rand%0d.done_width", i), done,
            (i < NRAND - 1 && nxt_b == 0) ? 1 : 0);
      cur_a = nxt_a;
      cur_b = nxt_b;
    end
    en = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
